// File: rtl/rv_isa_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rv_isa_pkg
// Description : Shared RV64I definitions for the decode and encode paths.
//               Holds opcodes, instruction formats, the decoded field bundle
//               and the stage-1 register layout of the encoder.
// Revision    : 1.0 - initial release
// ============================================================================
package rv_isa_pkg;

  // Base opcodes handled by the encoder
  localparam logic [6:0] OPC_LUI     = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
  localparam logic [6:0] OPC_JAL     = 7'b1101111;
  localparam logic [6:0] OPC_JALR    = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
  localparam logic [6:0] OPC_LOAD    = 7'b0000011;
  localparam logic [6:0] OPC_STORE   = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
  localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
  localparam logic [6:0] OPC_OP      = 7'b0110011;
  localparam logic [6:0] OPC_OP32    = 7'b0111011;

  typedef enum logic [2:0] {
    FMT_R   = 3'd0,
    FMT_I   = 3'd1,
    FMT_S   = 3'd2,
    FMT_B   = 3'd3,
    FMT_U   = 3'd4,
    FMT_J   = 3'd5,
    FMT_ILL = 3'd6
  } inst_fmt_e;

  typedef struct packed {
    logic [63:0] addr;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        width_32;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
  } decoded_inst_t;

  // Stage-1 register contents. The immediate has already been range-checked,
  // so only the 21 bits any format can place in the word are kept.
  typedef struct packed {
    inst_fmt_e   fmt;
    logic        illegal;
    logic [63:0] addr;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [20:0] imm;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
  } enc_stage_t;

  // True when imm is representable as a BITS-wide two's complement value,
  // i.e. every bit from BITS-1 upward equals the sign bit.
  function automatic logic imm_fits_signed(input logic [31:0] imm, input int bits);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < 32; i++) begin
      if ((i >= bits - 1) && (imm[i] != imm[31])) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage
`default_nettype wire

// File: rtl/inst_encode_pack.sv
`default_nettype none
// ============================================================================
// Module      : inst_encode_pack
// Description : Combinational packer: places already-validated fields into
//               the standard RV bit layout for the given format. FMT_ILL
//               produces an all-zero word.
// Revision    : 1.0 - initial release
// ============================================================================
module inst_encode_pack
  import rv_isa_pkg::*;
(
  input  inst_fmt_e   fmt,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [20:0] imm,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  output logic [31:0] instr
);

  logic is_shift;

  // Select the bit layout by format; shifts carry funct7 bits above shamt
  always_comb begin
    is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);
    instr    = 32'h0;
    case (fmt)
      FMT_R: instr = {funct7, rs2, rs1, funct3, rd, opcode};
      FMT_I: begin
        if ((opcode == OPC_OPIMM) && is_shift)
          instr = {funct7[6:1], imm[5:0], rs1, funct3, rd, opcode};
        else if ((opcode == OPC_OPIMM32) && is_shift)
          instr = {funct7, imm[4:0], rs1, funct3, rd, opcode};
        else
          instr = {imm[11:0], rs1, funct3, rd, opcode};
      end
      FMT_S: instr = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
      FMT_B: instr = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
      FMT_U: instr = {imm[19:0], rd, opcode};
      FMT_J: instr = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
      default: instr = 32'h0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/inst_encoder.sv
`default_nettype none
// ============================================================================
// Module      : inst_encoder
// Description : Two-stage valid/ready encoder turning a decoded_inst_t field
//               bundle back into a 32-bit RV64I word. Stage 1 classifies and
//               range-checks, stage 2 packs. Unencodable inputs still emit a
//               zero word flagged illegal so the stream stays address-aligned.
// Revision    : 1.0 - initial release
// ============================================================================
module inst_encoder
  import rv_isa_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  decoded_inst_t    in_inst,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_addr,
  output logic [31:0]      out_instr,
  output logic             out_illegal,
  output logic [CNT_W-1:0] enc_count,
  output logic [CNT_W-1:0] ill_count
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Stage-1 register
  logic       s1_valid_q, s1_valid_d;
  enc_stage_t s1_q, s1_d;
  // Stage-2 (output) register
  logic        out_valid_q, out_valid_d;
  logic [63:0] out_addr_q, out_addr_d;
  logic [31:0] out_instr_q, out_instr_d;
  logic        out_illegal_q, out_illegal_d;
  // Statistics
  logic [CNT_W-1:0] enc_count_q, enc_count_d;
  logic [CNT_W-1:0] ill_count_q, ill_count_d;

  // Handshake helpers
  logic s2_ready, in_ready_w, in_fire, s1_adv, out_fire;

  // Classification results for the incoming bundle
  inst_fmt_e  cls_fmt;
  logic       cls_f3_bad, cls_imm_bad, cls_illegal;
  enc_stage_t cls_stage;

  logic [31:0] packed_instr;

  // width_32 is re-derived from opcode/funct3 on decode, so it has no role here
  logic unused_width_32;
  assign unused_width_32 = in_inst.width_32;

  assign s2_ready   = !out_valid_q || out_ready;
  assign in_ready_w = !flush && (!s1_valid_q || s2_ready);
  assign in_fire    = in_valid && in_ready_w;
  assign s1_adv     = s1_valid_q && s2_ready;
  assign out_fire   = out_valid_q && out_ready;

  // Stage 1: determine format and check funct3 / immediate encodability
  always_comb begin
    cls_fmt     = FMT_ILL;
    cls_f3_bad  = 1'b0;
    cls_imm_bad = 1'b0;
    case (in_inst.opcode)
      OPC_LUI, OPC_AUIPC: begin
        cls_fmt     = FMT_U;
        cls_imm_bad = |in_inst.imm[31:20];
      end
      OPC_JAL: begin
        cls_fmt     = FMT_J;
        cls_imm_bad = !imm_fits_signed(in_inst.imm, 21) || in_inst.imm[0];
      end
      OPC_JALR: begin
        cls_fmt     = FMT_I;
        cls_f3_bad  = (in_inst.funct3 != 3'b000);
        cls_imm_bad = !imm_fits_signed(in_inst.imm, 12);
      end
      OPC_LOAD: begin
        cls_fmt     = FMT_I;
        cls_f3_bad  = (in_inst.funct3 == 3'b111);
        cls_imm_bad = !imm_fits_signed(in_inst.imm, 12);
      end
      OPC_OPIMM: begin
        cls_fmt = FMT_I;
        if ((in_inst.funct3 == 3'b001) || (in_inst.funct3 == 3'b101))
          cls_imm_bad = |in_inst.imm[31:6];
        else
          cls_imm_bad = !imm_fits_signed(in_inst.imm, 12);
      end
      OPC_OPIMM32: begin
        cls_fmt    = FMT_I;
        cls_f3_bad = !((in_inst.funct3 == 3'b000) || (in_inst.funct3 == 3'b001) ||
                       (in_inst.funct3 == 3'b101));
        if ((in_inst.funct3 == 3'b001) || (in_inst.funct3 == 3'b101))
          cls_imm_bad = |in_inst.imm[31:5];
        else
          cls_imm_bad = !imm_fits_signed(in_inst.imm, 12);
      end
      OPC_STORE: begin
        cls_fmt     = FMT_S;
        cls_f3_bad  = in_inst.funct3[2];
        cls_imm_bad = !imm_fits_signed(in_inst.imm, 12);
      end
      OPC_BRANCH: begin
        cls_fmt     = FMT_B;
        cls_f3_bad  = (in_inst.funct3 == 3'b010) || (in_inst.funct3 == 3'b011);
        cls_imm_bad = !imm_fits_signed(in_inst.imm, 13) || in_inst.imm[0];
      end
      OPC_OP: begin
        cls_fmt = FMT_R;
      end
      OPC_OP32: begin
        cls_fmt    = FMT_R;
        cls_f3_bad = (in_inst.funct3 == 3'b010) || (in_inst.funct3 == 3'b011) ||
                     (in_inst.funct3 == 3'b111);
      end
      default: cls_fmt = FMT_ILL;
    endcase

    cls_illegal       = (cls_fmt == FMT_ILL) || cls_f3_bad || cls_imm_bad;
    cls_stage.fmt     = cls_illegal ? FMT_ILL : cls_fmt;
    cls_stage.illegal = cls_illegal;
    cls_stage.addr    = in_inst.addr;
    cls_stage.opcode  = in_inst.opcode;
    cls_stage.rd      = in_inst.rd;
    cls_stage.rs1     = in_inst.rs1;
    cls_stage.rs2     = in_inst.rs2;
    cls_stage.imm     = in_inst.imm[20:0];
    cls_stage.funct3  = in_inst.funct3;
    cls_stage.funct7  = in_inst.funct7;
  end

  // Stage 2 packer works directly on the stage-1 register
  inst_encode_pack u_pack (
    .fmt    (s1_q.fmt),
    .opcode (s1_q.opcode),
    .rd     (s1_q.rd),
    .rs1    (s1_q.rs1),
    .rs2    (s1_q.rs2),
    .imm    (s1_q.imm),
    .funct3 (s1_q.funct3),
    .funct7 (s1_q.funct7),
    .instr  (packed_instr)
  );

  // Next-state: pipeline advance, flush clearing and statistics
  always_comb begin
    s1_valid_d    = s1_valid_q;
    s1_d          = s1_q;
    out_valid_d   = out_valid_q;
    out_addr_d    = out_addr_q;
    out_instr_d   = out_instr_q;
    out_illegal_d = out_illegal_q;
    enc_count_d   = enc_count_q;
    ill_count_d   = ill_count_q;

    if (in_fire) begin
      s1_valid_d = 1'b1;
      s1_d       = cls_stage;
    end else if (s1_adv) begin
      s1_valid_d = 1'b0;
    end

    if (s2_ready) out_valid_d = s1_valid_q;
    if (s1_adv) begin
      out_addr_d    = s1_q.addr;
      out_instr_d   = s1_q.illegal ? 32'h0 : packed_instr;
      out_illegal_d = s1_q.illegal;
    end

    // A word leaving in the flush cycle was delivered, so it is still counted
    if (out_fire) begin
      if (out_illegal_q) ill_count_d = ill_count_q + CNT_ONE;
      else               enc_count_d = enc_count_q + CNT_ONE;
    end

    if (flush) begin
      s1_valid_d  = 1'b0;
      out_valid_d = 1'b0;
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_q    <= 1'b0;
      s1_q          <= '0;
      out_valid_q   <= 1'b0;
      out_addr_q    <= 64'h0;
      out_instr_q   <= 32'h0;
      out_illegal_q <= 1'b0;
      enc_count_q   <= '0;
      ill_count_q   <= '0;
    end else begin
      s1_valid_q    <= s1_valid_d;
      s1_q          <= s1_d;
      out_valid_q   <= out_valid_d;
      out_addr_q    <= out_addr_d;
      out_instr_q   <= out_instr_d;
      out_illegal_q <= out_illegal_d;
      enc_count_q   <= enc_count_d;
      ill_count_q   <= ill_count_d;
    end
  end

  assign in_ready    = in_ready_w;
  assign out_valid   = out_valid_q;
  assign out_addr    = out_addr_q;
  assign out_instr   = out_instr_q;
  assign out_illegal = out_illegal_q;
  assign enc_count   = enc_count_q;
  assign ill_count   = ill_count_q;

endmodule
`default_nettype wire

// File: tb/tb_inst_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_inst_encoder
// Description : Self-checking bench for inst_encoder: directed vector table
//               plus hand-written stall, flush and reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_encoder;
  import rv_isa_pkg::*;

  logic          clk;
  logic          reset_n;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  decoded_inst_t in_inst;
  logic          out_valid;
  logic          out_ready;
  logic [63:0]   out_addr;
  logic [31:0]   out_instr;
  logic          out_illegal;
  logic [31:0]   enc_count;
  logic [31:0]   ill_count;

  int n_cmp = 0;
  int n_err = 0;

  inst_encoder #(.CNT_W(32)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_inst     (in_inst),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_addr    (out_addr),
    .out_instr   (out_instr),
    .out_illegal (out_illegal),
    .enc_count   (enc_count),
    .ill_count   (ill_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    decoded_inst_t inst;
    logic [31:0]   exp_instr;
    logic          exp_ill;
  } vec_t;

  vec_t tbl [0:20];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic decoded_inst_t mk(input logic [6:0] opc, input logic [4:0] rd,
                                       input logic [4:0] rs1, input logic [4:0] rs2,
                                       input logic [31:0] imm, input logic [2:0] f3,
                                       input logic [6:0] f7, input logic [63:0] addr);
    decoded_inst_t d;
    d.addr = addr; d.opcode = opc; d.rd = rd; d.rs1 = rs1; d.rs2 = rs2;
    d.imm = imm; d.width_32 = 1'b0; d.funct3 = f3; d.funct7 = f7;
    return d;
  endfunction

  // Starts and ends at posedge+1 with an empty pipeline
  task automatic run_vec(input int idx, input decoded_inst_t inst,
                         input logic [31:0] ei, input logic eill);
    int   lat;
    logic seen;
    in_inst   = inst;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat  = 0;
    seen = 1'b0;
    for (int k = 0; k < 6 && !seen; k++) begin
      @(negedge clk);
      lat++;
      if (out_valid) seen = 1'b1;
    end
    if (!seen) begin
      chk($sformatf("v%0d timeout", idx), 0, 1);
    end else begin
      chk($sformatf("v%0d latency", idx), lat, 2);
      chk($sformatf("v%0d instr", idx), out_instr, ei);
      chk($sformatf("v%0d illegal", idx), out_illegal, eill);
      chk($sformatf("v%0d addr", idx), out_addr, inst.addr);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    // Boundary cases first so the counters can be checked in isolation
    tbl[0]  = '{mk(OPC_OPIMM, 10, 10, 0, 32'd2048, 3'd0, 7'd0, 64'h0), 32'h0, 1'b1};
    tbl[1]  = '{mk(OPC_BRANCH, 0, 10, 11, 32'd6, 3'd0, 7'd0, 64'h0), 32'h00b50363, 1'b0};
    tbl[2]  = '{mk(OPC_BRANCH, 0, 10, 11, 32'd5, 3'd0, 7'd0, 64'h0), 32'h0, 1'b1};
    tbl[3]  = '{mk(7'h7f, 1, 2, 3, 32'd0, 3'd0, 7'd0, 64'h0), 32'h0, 1'b1};
    tbl[4]  = '{mk(OPC_OPIMM, 10, 10, 0, 32'd1, 3'd0, 7'd0, 64'h0), 32'h00150513, 1'b0};
    tbl[5]  = '{mk(OPC_STORE, 0, 2, 1, 32'd8, 3'd3, 7'd0, 64'h0), 32'h00113423, 1'b0};
    tbl[6]  = '{mk(OPC_BRANCH, 0, 10, 11, 32'd8, 3'd0, 7'd0, 64'h0), 32'h00b50463, 1'b0};
    tbl[7]  = '{mk(OPC_JAL, 1, 0, 0, 32'd16, 3'd0, 7'd0, 64'h0), 32'h010000ef, 1'b0};
    tbl[8]  = '{mk(OPC_LUI, 10, 0, 0, 32'h12345, 3'd0, 7'd0, 64'h0), 32'h12345537, 1'b0};
    tbl[9]  = '{mk(OPC_OPIMM, 10, 10, 0, 32'd63, 3'd5, 7'h20, 64'h0), 32'h43f55513, 1'b0};
    tbl[10] = '{mk(OPC_OPIMM, 10, 10, 0, 32'hffffffff, 3'd0, 7'd0, 64'h0), 32'hfff50513, 1'b0};
    tbl[11] = '{mk(OPC_OP, 10, 11, 12, 32'd0, 3'd0, 7'h00, 64'h0), 32'h00c58533, 1'b0};
    tbl[12] = '{mk(OPC_OP, 10, 11, 12, 32'd0, 3'd0, 7'h20, 64'h0), 32'h40c58533, 1'b0};
    tbl[13] = '{mk(OPC_JALR, 1, 2, 0, 32'd0, 3'd1, 7'd0, 64'h0), 32'h0, 1'b1};
    tbl[14] = '{mk(OPC_LUI, 10, 0, 0, 32'h100000, 3'd0, 7'd0, 64'h0), 32'h0, 1'b1};
    tbl[15] = '{mk(OPC_LOAD, 10, 2, 0, 32'hfffffff8, 3'd3, 7'd0, 64'h0), 32'hff813503, 1'b0};
    tbl[16] = '{mk(OPC_JAL, 0, 0, 0, 32'hfffffffc, 3'd0, 7'd0, 64'h0), 32'hffdff06f, 1'b0};
    tbl[17] = '{mk(OPC_OPIMM32, 10, 10, 0, 32'd31, 3'd1, 7'd0, 64'h0), 32'h01f5151b, 1'b0};
    tbl[18] = '{mk(OPC_OPIMM32, 10, 10, 0, 32'd32, 3'd1, 7'd0, 64'h0), 32'h0, 1'b1};
    tbl[19] = '{mk(OPC_AUIPC, 5, 0, 0, 32'hfffff, 3'd0, 7'd0, 64'h0), 32'hfffff297, 1'b0};
    tbl[20] = '{mk(OPC_OPIMM32, 10, 10, 0, 32'd1, 3'd2, 7'd0, 64'h0), 32'h0, 1'b1};
    for (int i = 0; i <= 20; i++) tbl[i].inst.addr = 64'h0000_0040_0000_0000 + 64'(i * 4);

    reset_n   = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_inst   = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset out_valid", out_valid, 0);
    chk("reset out_instr", out_instr, 0);
    chk("reset out_addr", out_addr, 0);
    chk("reset out_illegal", out_illegal, 0);
    chk("reset enc_count", enc_count, 0);
    chk("reset ill_count", ill_count, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Boundary vectors, then counter check
    for (int i = 0; i < 4; i++) run_vec(i, tbl[i].inst, tbl[i].exp_instr, tbl[i].exp_ill);
    chk("boundary ill_count", ill_count, 3);
    chk("boundary enc_count", enc_count, 1);

    for (int i = 4; i <= 20; i++) run_vec(i, tbl[i].inst, tbl[i].exp_instr, tbl[i].exp_ill);
    chk("table ill_count", ill_count, 7);
    chk("table enc_count", enc_count, 14);

    // Back-to-back 8 words with a 3-cycle downstream stall
    begin : b2b
      decoded_inst_t w [8];
      logic [31:0]   ew [8];
      logic [63:0]   ea [8];
      int            sent, recv;
      logic          ir, ov, stalled;
      logic [31:0]   oi, hold_i;
      logic [63:0]   oa, hold_a;
      for (int i = 0; i < 8; i++) begin
        ea[i] = 64'h2000 + 64'(i * 4);
        w[i]  = mk(OPC_OPIMM, 10, 10, 0, 32'(i), 3'd0, 7'd0, ea[i]);
        ew[i] = (32'(i) << 20) | 32'h00050513;
      end
      sent = 0; recv = 0; stalled = 1'b0; hold_i = 32'h0; hold_a = 64'h0;
      for (int c = 0; c < 40 && recv < 8; c++) begin
        in_valid = (sent < 8);
        if (sent < 8) in_inst = w[sent];
        out_ready = !(c >= 3 && c <= 5);
        @(negedge clk);
        ir = in_ready; ov = out_valid; oi = out_instr; oa = out_addr;
        if (c == 4) chk("b2b in_ready full", ir, 0);
        if (stalled) begin
          chk($sformatf("b2b c%0d stall valid", c), ov, 1);
          chk($sformatf("b2b c%0d stall instr", c), oi, hold_i);
          chk($sformatf("b2b c%0d stall addr", c), oa, hold_a);
        end
        if (ov && !out_ready) begin
          stalled = 1'b1; hold_i = oi; hold_a = oa;
        end else begin
          stalled = 1'b0;
        end
        if (ov && out_ready) begin
          chk($sformatf("b2b w%0d instr", recv), oi, ew[recv]);
          chk($sformatf("b2b w%0d addr", recv), oa, ea[recv]);
          recv++;
        end
        if (in_valid && ir) sent++;
        @(posedge clk); #1;
      end
      in_valid = 1'b0;
      chk("b2b words received", recv, 8);
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        chk("b2b no duplicate", out_valid, 0);
      end
      @(posedge clk); #1;
      chk("b2b enc_count", enc_count, 22);
      chk("b2b ill_count", ill_count, 7);
    end

    // Flush with two words in flight and a stalled output
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_inst   = tbl[4].inst;
    @(posedge clk); #1;
    in_inst   = tbl[5].inst;
    @(posedge clk); #1;
    flush     = 1'b1;
    in_inst   = tbl[6].inst;
    @(negedge clk);
    chk("flush in_ready", in_ready, 0);
    chk("flush pre out_valid", out_valid, 1);
    @(posedge clk); #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("flush out_valid", out_valid, 0);
    chk("flush enc_count", enc_count, 22);
    chk("flush ill_count", ill_count, 7);
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("flush dropped all", out_valid, 0);
    @(posedge clk); #1;

    // Flush in the same cycle as an output transfer: that word is counted
    in_valid = 1'b1;
    in_inst  = tbl[4].inst;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    flush = 1'b1;
    @(negedge clk);
    chk("flush+xfer pre valid", out_valid, 1);
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush+xfer enc_count", enc_count, 23);
    chk("flush+xfer out_valid", out_valid, 0);

    // Asynchronous reset with a full pipeline
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_inst   = tbl[4].inst;
    @(posedge clk); #1;
    in_inst   = tbl[5].inst;
    @(posedge clk); #1;
    in_valid  = 1'b0;
    @(negedge clk);
    chk("rst pre out_instr", out_instr, 32'h00150513);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async rst out_valid", out_valid, 0);
    chk("async rst out_instr", out_instr, 0);
    chk("async rst out_addr", out_addr, 0);
    chk("async rst out_illegal", out_illegal, 0);
    chk("async rst enc_count", enc_count, 0);
    chk("async rst ill_count", ill_count, 0);
    @(negedge clk);
    reset_n   = 1'b1;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("post rst no words", out_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
